mic1_hs_core: RTL and testbench

//  Next-generation MIC-1 microarchitecture core: datapath, microsequencer and memory sequencer in one block.

---
 rtl/mic1_hs_core.sv | 200 ++++++++++++++++++++
 tb/tb_mic1_hs_core.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic1_hs_core.sv
// MIC-1 core: datapath, registered microsequencer and req/ack memory sequencer; MIC1_PERF_CNT_EN adds perf counters.
// Latency: one microinstruction per clk in EXEC; a memory MIR adds MEMW cycles until the last ack is seen.
// Backpressure: stalls in MEMW while dmem/imem requests await ack; run=0 holds between microinstructions.
module mic1_hs_core #(
    parameter int              DW       = 32,
    parameter int              MPC_W    = 9,
    parameter logic [DW-1:0]   SP_INIT  = DW'('h60),
    parameter logic [DW-1:0]   LV_INIT  = DW'('h50),
    parameter logic [DW-1:0]   CPP_INIT = DW'('h48)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               run,
    output logic [MPC_W-1:0]   mp_addr,
    input  logic [26+MPC_W:0]  mp_rdata,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DW-1:0]      dmem_addr,
    output logic [DW-1:0]      dmem_wdata,
    input  logic               dmem_ack,
    input  logic [DW-1:0]      dmem_rdata,
    output logic               imem_req,
    output logic [DW-1:0]      imem_addr,
    input  logic               imem_ack,
    input  logic [7:0]         imem_rdata,
    output logic               busy,
    output logic               err,
`ifdef MIC1_PERF_CNT_EN
    output logic [31:0]        perf_cyc,
    output logic [31:0]        perf_mir,
    output logic [31:0]        perf_stall,
`endif
    input  logic [3:0]         dbg_sel,
    output logic [DW-1:0]      dbg_data
);

    typedef enum logic {EXEC, MEMW} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      mar, mdr, pc, sp, lv, cpp, tos, opc, h;
    logic [7:0]         mbr;
    logic [MPC_W-1:0]   mpc;

    logic [MPC_W-1:0]   nxt;
    logic               jmpc, jamn, jamz;
    logic [1:0]         sh;
    logic               f0, f1, ena, enb, inva, inc;
    logic [8:0]         c_en;
    logic               mem_wr, mem_rd, mem_fetch;
    logic [3:0]         b_sel;

    assign {nxt, jmpc, jamn, jamz, sh, f0, f1, ena, enb, inva, inc,
            c_en, mem_wr, mem_rd, mem_fetch, b_sel} = mp_rdata;

    logic [DW-1:0]      b_bus, a_op, b_op, alu_out, c_bus;
    logic               b_bad, n_flag, z_flag, jam;
    logic [MPC_W-1:0]   mpc_next;
    logic               exec, mem_any, d_done, i_done;

    always_comb begin
        b_bus = '0;
        b_bad = 1'b0;
        case (b_sel)
            4'd0:    b_bus = mdr;
            4'd1:    b_bus = pc;
            4'd2:    b_bus = {{(DW-8){mbr[7]}}, mbr};
            4'd3:    b_bus = DW'(mbr);
            4'd4:    b_bus = sp;
            4'd5:    b_bus = lv;
            4'd6:    b_bus = cpp;
            4'd7:    b_bus = tos;
            4'd8:    b_bus = opc;
            default: b_bad = 1'b1;
        endcase
    end

    always_comb begin
        a_op = ena ? h : '0;
        if (inva) a_op = ~a_op;
        b_op = enb ? b_bus : '0;
        case ({f0, f1})
            2'b00:   alu_out = a_op & b_op;
            2'b01:   alu_out = a_op | b_op;
            2'b10:   alu_out = ~b_op;
            default: alu_out = a_op + b_op + DW'(inc);
        endcase
        case (sh)
            2'd1:    c_bus = {alu_out[DW-1], alu_out[DW-1:1]};
            2'd2:    c_bus = {alu_out[DW-9:0], 8'h00};
            default: c_bus = alu_out;
        endcase
    end

    // N follows the shifted C bus, Z the unshifted ALU result
    assign n_flag   = c_bus[DW-1];
    assign z_flag   = (alu_out == '0);
    assign jam      = (jamz & z_flag) | (jamn & n_flag);
    assign mpc_next = nxt | (jmpc ? MPC_W'(mbr) : MPC_W'({jam, 8'h00}));

    assign exec     = (state_q == EXEC) && run;
    assign mem_any  = mem_wr | mem_rd | mem_fetch;
    assign d_done   = !dmem_req || dmem_ack;
    assign i_done   = !imem_req || imem_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            EXEC:    if (exec && mem_any) state_d = MEMW;
            MEMW:    if (d_done && i_done) state_d = EXEC;
            default: state_d = EXEC;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= EXEC;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mar <= '0;  mdr <= '0;  pc  <= '1;
            sp  <= SP_INIT;  lv <= LV_INIT;  cpp <= CPP_INIT;
            tos <= '0;  opc <= '0;  h   <= '0;
            mbr <= '0;  mpc <= '0;
            dmem_req <= 1'b0;  dmem_we <= 1'b0;  imem_req <= 1'b0;
            err <= 1'b0;
        end else if (exec) begin
            if (c_en[0]) mar <= c_bus;
            if (c_en[1]) mdr <= c_bus;
            if (c_en[2]) pc  <= c_bus;
            if (c_en[3]) sp  <= c_bus;
            if (c_en[4]) lv  <= c_bus;
            if (c_en[5]) cpp <= c_bus;
            if (c_en[6]) tos <= c_bus;
            if (c_en[7]) opc <= c_bus;
            if (c_en[8]) h   <= c_bus;
            mpc <= mpc_next;
            if (b_bad || (mem_rd && mem_wr)) err <= 1'b1;
            // rd+wr collapses to a write
            if (mem_any) begin
                dmem_req <= mem_rd | mem_wr;
                dmem_we  <= mem_wr;
                imem_req <= mem_fetch;
            end
        end else if (state_q == MEMW) begin
            if (dmem_req && dmem_ack) begin
                dmem_req <= 1'b0;
                if (!dmem_we) mdr <= dmem_rdata;
            end
            if (imem_req && imem_ack) begin
                imem_req <= 1'b0;
                mbr      <= imem_rdata;
            end
        end
    end

`ifdef MIC1_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cyc   <= '0;
            perf_mir   <= '0;
            perf_stall <= '0;
        end else begin
            if (run)               perf_cyc   <= perf_cyc + 32'd1;
            if (exec)              perf_mir   <= perf_mir + 32'd1;
            if (state_q == MEMW)   perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

    always_comb begin
        dbg_data = '0;
        case (dbg_sel)
            4'd0:  dbg_data = mar;
            4'd1:  dbg_data = mdr;
            4'd2:  dbg_data = pc;
            4'd3:  dbg_data = sp;
            4'd4:  dbg_data = lv;
            4'd5:  dbg_data = cpp;
            4'd6:  dbg_data = tos;
            4'd7:  dbg_data = opc;
            4'd8:  dbg_data = h;
            4'd9:  dbg_data = DW'(mbr);
            4'd10: dbg_data = DW'(mpc);
`ifdef MIC1_PERF_CNT_EN
            4'd11: dbg_data = DW'(perf_cyc);
            4'd12: dbg_data = DW'(perf_mir);
            4'd13: dbg_data = DW'(perf_stall);
`endif
            default: dbg_data = '0;
        endcase
    end

    assign mp_addr    = mpc;
    assign dmem_addr  = mar;
    assign dmem_wdata = mdr;
    assign imem_addr  = pc;
    assign busy       = (state_q == MEMW);

endmodule

// File: tb/tb_mic1_hs_core.sv
// Randomized bench for mic1_hs_core against a microinstruction-level reference model.
module tb_mic1_hs_core;

    logic        clk = 1'b0;
    logic        resetn;
    logic        run;
    logic [8:0]  mp_addr;
    logic [35:0] mp_rdata;
    logic        dmem_req, dmem_we, dmem_ack, imem_req, imem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata, imem_addr;
    logic [7:0]  imem_rdata;
    logic        busy, err;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_data;

    always #50 clk = ~clk;

    mic1_hs_core #(.DW(32), .MPC_W(9)) dut (
        .clk(clk), .resetn(resetn), .run(run),
        .mp_addr(mp_addr), .mp_rdata(mp_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .busy(busy), .err(err),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference state, indexed like dbg_sel: 0 MAR,1 MDR,2 PC,3 SP,4 LV,5 CPP,6 TOS,7 OPC,8 H
    logic [31:0] m_r [9];
    logic [7:0]  m_mbr;
    logic [8:0]  m_mpc;
    logic        m_err, m_we;

    function automatic logic [35:0] mk(input logic [8:0] nx, input logic [2:0] jmp, input logic [1:0] s,
                                       input logic [5:0] alu, input logic [8:0] c, input logic [2:0] mem,
                                       input logic [3:0] b);
        return {nx, jmp, s, alu, c, mem, b};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) m_r[i] = 32'h0;
        m_r[2] = 32'hFFFF_FFFF;
        m_r[3] = 32'h60;
        m_r[4] = 32'h50;
        m_r[5] = 32'h48;
        m_mbr = 8'h0; m_mpc = 9'h0; m_err = 1'b0; m_we = 1'b0;
    endtask

    task automatic model_exec(input logic [35:0] mir, output logic pd, output logic pi);
        logic [3:0]  b;
        logic [5:0]  alu;
        logic [31:0] bv, av, res, cv;
        logic        z, n;
        b   = mir[3:0];
        alu = mir[21:16];
        if (b == 0)                bv = m_r[1];
        else if (b == 1)           bv = m_r[2];
        else if (b == 2)           bv = {{24{m_mbr[7]}}, m_mbr};
        else if (b == 3)           bv = {24'h0, m_mbr};
        else if (b >= 4 && b <= 8) bv = m_r[b - 1];
        else begin bv = 32'h0; m_err = 1'b1; end
        av = alu[3] ? m_r[8] : 32'h0;
        if (alu[1]) av = ~av;
        if (!alu[2]) bv = 32'h0;
        case (alu[5:4])
            2'd0: res = av & bv;
            2'd1: res = av | bv;
            2'd2: res = ~bv;
            default: res = av + bv + {31'h0, alu[0]};
        endcase
        if (mir[23:22] == 2'd1)      cv = (res >> 1) | (res & 32'h8000_0000);
        else if (mir[23:22] == 2'd2) cv = res * 256;
        else                         cv = res;
        z = (res == 0);
        n = cv[31];
        if (mir[26])
            m_mpc = mir[35:27] | {1'b0, m_mbr};
        else
            m_mpc = mir[35:27] | (((mir[24] && z) || (mir[25] && n)) ? 9'h100 : 9'h000);
        for (int i = 0; i < 9; i++) if (mir[7 + i]) m_r[i] = cv;
        if (mir[5] && mir[6]) m_err = 1'b1;
        pd = mir[5] | mir[6];
        pi = mir[4];
        if (pd) m_we = mir[6];
    endtask

    task automatic check_regs();
        logic [31:0] exp;
        for (int s = 0; s < 16; s++) begin
            dbg_sel = 4'(s);
            #1;
            if (s < 9)        exp = m_r[s];
            else if (s == 9)  exp = {24'h0, m_mbr};
            else if (s == 10) exp = {23'h0, m_mpc};
            else              exp = 32'h0;
            check_eq($sformatf("dbg%0d", s), dbg_data, exp);
        end
        check_eq("err", err, m_err);
        check_eq("busy_idle", busy, 0);
    endtask

    // Entered away from clock edges with the core in EXEC; leaves it the same way.
    task automatic do_mir(input logic [35:0] mir, input logic run_v, input int dlat, input int ilat,
                          input logic [31:0] ddata, input logic [7:0] idata);
        logic pd, pi;
        int   c;
        pd = 1'b0; pi = 1'b0;
        mp_rdata   = mir;
        run        = run_v;
        dmem_ack   = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
        imem_ack   = ($urandom_range(0, 3) == 0);
        imem_rdata = 8'($urandom);
        #1;
        check_eq("mp_addr", mp_addr, m_mpc);
        check_eq("busy_exec", busy, 0);
        check_eq("reqs_exec", {dmem_req, imem_req}, 0);
        @(posedge clk); #2;
        dmem_ack = 1'b0; imem_ack = 1'b0;
        if (run_v) model_exec(mir, pd, pi);
        c = 0;
        while ((pd || pi) && c < 40) begin
            run        = 1'($urandom_range(0, 1));
            dbg_sel    = 4'd9;
            dmem_ack   = pd ? (c == dlat) : ($urandom_range(0, 3) == 0);
            dmem_rdata = (pd && c == dlat) ? ddata : $urandom;
            imem_ack   = pi ? (c == ilat) : ($urandom_range(0, 3) == 0);
            imem_rdata = (pi && c == ilat) ? idata : 8'($urandom);
            #1;
            check_eq("busy_memw", busy, 1);
            check_eq("dmem_req", dmem_req, pd);
            check_eq("imem_req", imem_req, pi);
            if (pd) begin
                check_eq("dmem_addr", dmem_addr, m_r[0]);
                check_eq("dmem_we", dmem_we, m_we);
                if (m_we) check_eq("dmem_wdata", dmem_wdata, m_r[1]);
            end
            if (pi) check_eq("imem_addr", imem_addr, m_r[2]);
            check_eq("mbr_memw", dbg_data, {24'h0, m_mbr});
            @(posedge clk); #2;
            if (pd && c == dlat) begin pd = 1'b0; if (!m_we) m_r[1] = ddata; end
            if (pi && c == ilat) begin pi = 1'b0; m_mbr = idata; end
            dmem_ack = 1'b0; imem_ack = 1'b0;
            c++;
        end
        if (pd || pi) check_eq("mem_timeout", 1, 0);
        check_regs();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        model_reset();
        resetn = 1'b1;
        #1;
    endtask

    task automatic peek(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        dbg_sel = sel;
        #1;
        check_eq(tag, dbg_data, exp);
    endtask

    initial begin
        logic [35:0] mir;
        logic [31:0] lo, hi;
        resetn = 1'b0; run = 1'b0; mp_rdata = '0; dbg_sel = '0;
        dmem_ack = 1'b0; dmem_rdata = '0; imem_ack = 1'b0; imem_rdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_regs();
        check_eq("reqs_reset", {dmem_req, imem_req, dmem_we}, 0);
        resetn = 1'b1;
        @(posedge clk); #2;

        // H = LV + 1
        do_mir(mk(9'h023, 3'b000, 2'd0, 6'b110101, 9'h100, 3'b000, 4'd5), 1'b1, 0, 0, 32'h0, 8'h0);
        peek("h_lv_plus1", 4'd8, 32'h51);
        check_eq("mpc_next", mp_addr, 9'h023);

        // MAR = SP; rd, ack after 3 idle MEMW cycles
        do_mir(mk(9'h001, 3'b000, 2'd0, 6'b110100, 9'h001, 3'b010, 4'd4), 1'b1, 3, 0, 32'hDEADBEEF, 8'h0);
        peek("mdr_read", 4'd1, 32'hDEADBEEF);

        // Parallel fetch+read, imem acks first; then JMPC on the fetched byte
        do_mir(mk(9'h002, 3'b000, 2'd0, 6'b000000, 9'h000, 3'b011, 4'd0), 1'b1, 3, 2, $urandom, 8'h10);
        do_mir(mk(9'h101, 3'b100, 2'd0, 6'b000000, 9'h000, 3'b000, 4'd0), 1'b1, 0, 0, 32'h0, 8'h0);
        check_eq("jmpc", mp_addr, 9'h111);

        // JAMZ on zero result, JAMN on 'h8000_0000
        do_mir(mk(9'h005, 3'b001, 2'd0, 6'b000000, 9'h000, 3'b000, 4'd0), 1'b1, 0, 0, 32'h0, 8'h0);
        check_eq("jamz", mp_addr, 9'h105);
        do_mir(mk(9'h000, 3'b000, 2'd0, 6'b000000, 9'h000, 3'b010, 4'd0), 1'b1, 1, 0, 32'h8000_0000, 8'h0);
        do_mir(mk(9'h005, 3'b010, 2'd0, 6'b110100, 9'h000, 3'b000, 4'd0), 1'b1, 0, 0, 32'h0, 8'h0);
        check_eq("jamn", mp_addr, 9'h105);

        // Invalid B select feeds zero and flags err
        do_mir(mk(9'h000, 3'b000, 2'd0, 6'b110100, 9'h100, 3'b000, 4'd12), 1'b1, 0, 0, 32'h0, 8'h0);
        peek("h_bad_b", 4'd8, 32'h0);
        check_eq("err_bad_b", err, 1);

        // rd+wr collapses to a write and sets err
        do_reset();
        check_eq("err_cleared", err, 0);
        do_mir(mk(9'h000, 3'b000, 2'd0, 6'b000000, 9'h000, 3'b110, 4'd0), 1'b1, 2, 0, 32'h0, 8'h0);
        check_eq("err_rdwr", err, 1);

        // Reset in the middle of MEMW
        mp_rdata = mk(9'h007, 3'b000, 2'd0, 6'b000000, 9'h000, 3'b011, 4'd0);
        run = 1'b1;
        @(posedge clk); #2;
        run = 1'b0;
        @(posedge clk); #2;
        check_eq("busy_pre_rst", busy, 1);
        check_eq("reqs_pre_rst", {dmem_req, imem_req}, 2'b11);
        resetn = 1'b0;
        #1;
        model_reset();
        check_eq("reqs_mid_rst", {dmem_req, imem_req, dmem_we}, 0);
        check_regs();
        resetn = 1'b1;
        @(posedge clk); #2;

        for (int k = 0; k < 300; k++) begin
            lo = $urandom;
            hi = $urandom;
            mir = {hi[3:0], lo};
            mir[3:0] = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            mir[6:4] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if ($urandom_range(0, 39) == 0) do_reset();
            do_mir(mir, ($urandom_range(0, 4) != 0), $urandom_range(0, 4), $urandom_range(0, 4),
                   $urandom, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
